// File: rtl/selevy_fetch.sv
// selevy_fetch: sequential instruction fetch unit.
// Issues one ROM read per cycle while there is room in a 2-entry {inst, pc}
// queue, accounting for the single read that may still be in flight.
// A redirect flushes the queue, discards any in-flight read and restarts
// fetching at the (word-aligned) target on the following cycle.
module selevy_fetch #(
    parameter int          ROM_AW   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              reset,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc
);

    logic [31:0] pc_reg;
    logic        pend_reg;
    logic [31:0] pend_pc_reg;
    logic [1:0]  count_reg;
    logic        head_reg;

    logic [31:0] fifo_inst_reg [2];
    logic [31:0] fifo_pc_reg   [2];

    logic        pop;
    logic        push;
    logic        tail;
    logic [2:0]  occ_next;
    logic        unused_bits;

    // Low address bits of a redirect target are dropped by word alignment.
    assign unused_bits = ^redirect_pc[1:0];

    assign inst_valid = (count_reg != 2'd0);
    assign pop        = inst_valid & inst_ready & ~redirect_valid;
    assign push       = pend_reg & ~redirect_valid;

    // Occupancy the queue will have once the in-flight read lands and any
    // pop this cycle retires; a new read is only allowed if it will fit.
    assign occ_next = {1'b0, count_reg} + {2'b00, pend_reg} - {2'b00, pop};
    assign rom_en   = reset & ~redirect_valid & (occ_next < 3'd2);
    assign rom_addr = pc_reg[ROM_AW+1:2];

    // With count < 2 whenever a push happens, the free slot is head + count.
    assign tail = head_reg ^ count_reg[0];

    // Outputs come from registered queue state only; zero when empty.
    assign inst    = inst_valid ? fifo_inst_reg[head_reg] : 32'h0;
    assign inst_pc = inst_valid ? fifo_pc_reg[head_reg]   : 32'h0;

    // Control state: pc, in-flight flag, queue pointer and occupancy.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            pc_reg      <= RESET_PC;
            pend_reg    <= 1'b0;
            pend_pc_reg <= 32'h0;
            count_reg   <= 2'd0;
            head_reg    <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg    <= {redirect_pc[31:2], 2'b00};
            pend_reg  <= 1'b0;
            count_reg <= 2'd0;
            head_reg  <= 1'b0;
        end else begin
            if (rom_en) begin
                pc_reg      <= pc_reg + 32'd4;
                pend_pc_reg <= pc_reg;
            end
            pend_reg  <= rom_en;
            if (pop) begin
                head_reg <= ~head_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Queue storage: each entry captures the returning ROM word when it is the tail.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (reset && push && (tail == gi[0])) begin
                    fifo_inst_reg[gi] <= rom_data;
                    fifo_pc_reg[gi]   <= pend_pc_reg;
                end
            end
        end
    endgenerate

endmodule
